// File: rtl/pin_seq_pkg.sv
// rtl/pin_seq_pkg.sv - shared states, register map and address helper for pin_sequencer
package pin_seq_pkg;

    typedef enum logic [7:0] {
        ST_IDLE      = 8'b0000_0001,
        ST_WR_DUTY   = 8'b0000_0010,
        ST_WR_ANTI   = 8'b0000_0100,
        ST_WR_CYC    = 8'b0000_1000,
        ST_WR_INF    = 8'b0001_0000,
        ST_WAIT_TIME = 8'b0010_0000,
        ST_GO        = 8'b0100_0000,
        ST_CLEAR     = 8'b1000_0000
    } state_t;

    localparam logic [20:0] OFF_DUTY        = 21'd4;
    localparam logic [20:0] OFF_ANTI        = 21'd8;
    localparam logic [20:0] OFF_CYC         = 21'd12;
    localparam logic [20:0] OFF_INF         = 21'd16;
    localparam logic [20:0] ADDR_GLOBAL_CMD = 21'd0;
    localparam logic [15:0] GLOBAL_START    = 16'd1;
    localparam logic [15:0] GLOBAL_STOP     = 16'd0;

    // Block 0 is the global command register, so pin p lives one stride further up.
    function automatic logic [20:0] pin_base(input int unsigned pin, input int unsigned stride);
        return 21'((pin + 32'd1) * stride);
    endfunction

endpackage

// File: rtl/timestamp_counter.sv
// rtl/timestamp_counter.sv - free-running wrapping tick counter
module timestamp_counter #(
    parameter int TS_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic [TS_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + TS_W'(1);
        end
    end

endmodule

// File: rtl/pin_sequencer.sv
// rtl/pin_sequencer.sv - serialises one timed pin command onto the register bus and launches it
module pin_sequencer
    import pin_seq_pkg::*;
#(
    parameter int          NUM_PINS   = 8,
    parameter int          PIN_STRIDE = 32,
    parameter logic [20:0] IDLE_ADDR  = 21'h1FFFFF,
    parameter int          TS_W       = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(NUM_PINS)-1:0] cmd_pin,
    input  logic [15:0]                 cmd_duty,
    input  logic [15:0]                 cmd_anti_duty,
    input  logic [15:0]                 cmd_cycles,
    input  logic                        cmd_run_inf,
    input  logic [TS_W-1:0]             cmd_start_time,
    input  logic                        abort,
    output logic [20:0]                 bus_addr,
    output logic [15:0]                 bus_data,
    output logic                        bus_we,
    output logic [TS_W-1:0]             timestamp,
    output logic                        busy,
    output logic                        start_pulse
);

    localparam int PIN_W = $clog2(NUM_PINS);

    state_t            state;
    state_t            state_next;
    logic [PIN_W-1:0]  pin_q;
    logic [15:0]       duty_q;
    logic [15:0]       anti_q;
    logic [15:0]       cycles_q;
    logic              run_inf_q;
    logic [TS_W-1:0]   start_q;
    logic [PIN_W-1:0]  pin_eff;
    logic [15:0]       duty_eff;
    logic              accept;
    logic              pin_valid;
    logic              reached;
    logic [TS_W-1:0]   elapsed;
    logic [20:0]       base;
    logic [20:0]       addr_next;
    logic [15:0]       data_next;
    logic              we_next;
    logic              pulse_next;

    timestamp_counter #(.TS_W(TS_W)) u_timestamp (
        .clk   (clk),
        .reset (reset),
        .count (timestamp)
    );

    assign accept    = cmd_valid & cmd_ready;
    assign pin_valid = 32'(cmd_pin) < NUM_PINS;
    // Modular difference: MSB clear means the start time is at most half a wrap behind.
    assign elapsed   = timestamp - start_q;
    assign reached   = ~elapsed[TS_W-1];

    // Fields track the host while idle, so they hold the accepted command afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            pin_q     <= '0;
            duty_q    <= '0;
            anti_q    <= '0;
            cycles_q  <= '0;
            run_inf_q <= 1'b0;
            start_q   <= '0;
        end else if (state == ST_IDLE) begin
            pin_q     <= cmd_pin;
            duty_q    <= cmd_duty;
            anti_q    <= cmd_anti_duty;
            cycles_q  <= cmd_cycles;
            run_inf_q <= cmd_run_inf;
            start_q   <= cmd_start_time;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_CLEAR;
        end else begin
            case (state)
                ST_IDLE:      if (accept) state_next = pin_valid ? ST_WR_DUTY : ST_CLEAR;
                ST_WR_DUTY:   state_next = ST_WR_ANTI;
                ST_WR_ANTI:   state_next = ST_WR_CYC;
                ST_WR_CYC:    state_next = ST_WR_INF;
                ST_WR_INF:    state_next = ST_WAIT_TIME;
                ST_WAIT_TIME: if (reached) state_next = ST_GO;
                ST_GO:        state_next = ST_CLEAR;
                ST_CLEAR:     state_next = ST_IDLE;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are computed for the state being entered and registered, so the
    // duty write uses the host fields directly on the accepting edge.
    assign pin_eff  = (state == ST_IDLE) ? cmd_pin  : pin_q;
    assign duty_eff = (state == ST_IDLE) ? cmd_duty : duty_q;

    always_comb begin
        addr_next  = IDLE_ADDR;
        data_next  = '0;
        we_next    = 1'b0;
        pulse_next = 1'b0;
        base       = pin_base(32'(pin_eff), PIN_STRIDE);
        case (state_next)
            ST_WR_DUTY: begin
                addr_next = base + OFF_DUTY;
                data_next = duty_eff;
                we_next   = 1'b1;
            end
            ST_WR_ANTI: begin
                addr_next = base + OFF_ANTI;
                data_next = anti_q;
                we_next   = 1'b1;
            end
            ST_WR_CYC: begin
                addr_next = base + OFF_CYC;
                data_next = cycles_q;
                we_next   = 1'b1;
            end
            ST_WR_INF: begin
                addr_next = base + OFF_INF;
                data_next = {15'b0, run_inf_q};
                we_next   = 1'b1;
            end
            ST_GO: begin
                addr_next  = ADDR_GLOBAL_CMD;
                data_next  = GLOBAL_START;
                we_next    = 1'b1;
                pulse_next = 1'b1;
            end
            ST_CLEAR: begin
                addr_next = ADDR_GLOBAL_CMD;
                data_next = GLOBAL_STOP;
                we_next   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_addr    <= IDLE_ADDR;
            bus_data    <= '0;
            bus_we      <= 1'b0;
            start_pulse <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            bus_addr    <= addr_next;
            bus_data    <= data_next;
            bus_we      <= we_next;
            start_pulse <= pulse_next;
            cmd_ready   <= (state_next == ST_IDLE);
            busy        <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_pin_sequencer.sv
// tb/tb_pin_sequencer.sv - directed self-checking bench for pin_sequencer
module tb_pin_sequencer;

    localparam logic [20:0] IA = 21'h1FFFFF;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_pin;
    logic [15:0] cmd_duty;
    logic [15:0] cmd_anti_duty;
    logic [15:0] cmd_cycles;
    logic        cmd_run_inf;
    logic [31:0] cmd_start_time;
    logic        abort;
    logic [20:0] bus_addr;
    logic [15:0] bus_data;
    logic        bus_we;
    logic [31:0] timestamp;
    logic        busy;
    logic        start_pulse;

    logic        cmd_valid2;
    logic        cmd_ready2;
    logic [2:0]  cmd_pin2;
    logic [7:0]  cmd_start_time2;
    logic [20:0] bus_addr2;
    logic [15:0] bus_data2;
    logic        bus_we2;
    logic [7:0]  timestamp2;
    logic        busy2;
    logic        start_pulse2;

    int vectors = 0;
    int miscompares = 0;
    int n;
    int viol;
    int pulses;

    pin_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_pin(cmd_pin), .cmd_duty(cmd_duty), .cmd_anti_duty(cmd_anti_duty),
        .cmd_cycles(cmd_cycles), .cmd_run_inf(cmd_run_inf), .cmd_start_time(cmd_start_time),
        .abort(abort), .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
        .timestamp(timestamp), .busy(busy), .start_pulse(start_pulse)
    );

    // Narrow timestamp for wrap coverage, six pins so out-of-range indices are encodable.
    pin_sequencer #(.NUM_PINS(6), .TS_W(8)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_pin(cmd_pin2), .cmd_duty(cmd_duty), .cmd_anti_duty(cmd_anti_duty),
        .cmd_cycles(cmd_cycles), .cmd_run_inf(cmd_run_inf), .cmd_start_time(cmd_start_time2),
        .abort(abort), .bus_addr(bus_addr2), .bus_data(bus_data2), .bus_we(bus_we2),
        .timestamp(timestamp2), .busy(busy2), .start_pulse(start_pulse2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [20:0] a, input logic [15:0] d,
                        input logic we, input logic sp, input logic rdy, input logic bsy);
        @(negedge clk);
        check(tag, 64'({bus_addr, bus_data, bus_we, start_pulse, cmd_ready, busy}),
                   64'({a, d, we, sp, rdy, bsy}));
    endtask

    task automatic step2(input string tag, input logic [20:0] a, input logic [15:0] d,
                         input logic we, input logic sp, input logic rdy, input logic bsy);
        @(negedge clk);
        check(tag, 64'({bus_addr2, bus_data2, bus_we2, start_pulse2, cmd_ready2, busy2}),
                   64'({a, d, we, sp, rdy, bsy}));
    endtask

    task automatic send(input logic [2:0] p, input logic [15:0] du, input logic [15:0] an,
                        input logic [15:0] cy, input logic inf, input logic [31:0] st);
        int k;
        cmd_pin = p; cmd_duty = du; cmd_anti_duty = an; cmd_cycles = cy;
        cmd_run_inf = inf; cmd_start_time = st; cmd_valid = 1'b1;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; abort = 1'b0; cmd_valid = 1'b0; cmd_pin = '0; cmd_duty = '0;
        cmd_anti_duty = '0; cmd_cycles = '0; cmd_run_inf = 1'b0; cmd_start_time = '0;
        cmd_valid2 = 1'b0; cmd_pin2 = '0; cmd_start_time2 = '0;

        repeat (3) @(negedge clk);
        check("reset_outs", 64'({bus_addr, bus_data, bus_we, start_pulse, cmd_ready, busy}),
                            64'({IA, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("reset_ts", 64'(timestamp), 64'd0);
        reset = 1'b0;
        step("post_reset", IA, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_reset_ts", 64'(timestamp), 64'd1);

        // Basic launch: pin 2 -> base 96
        send(3'd2, 16'd5, 16'd3, 16'd4, 1'b0, 32'd0);
        step("basic_duty",  21'd100, 16'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        step("basic_anti",  21'd104, 16'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        step("basic_cyc",   21'd108, 16'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        step("basic_inf",   21'd112, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("basic_wait",  IA,      16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("basic_go",    21'd0,   16'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("basic_clear", 21'd0,   16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("basic_idle",  IA,      16'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Delayed start: pin 0 -> base 32, GO visible when timestamp reads 1001
        send(3'd0, 16'hABCD, 16'h1234, 16'd7, 1'b1, 32'd1000);
        step("delay_duty", 21'd36, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b1);
        step("delay_anti", 21'd40, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        step("delay_cyc",  21'd44, 16'd7,    1'b1, 1'b0, 1'b0, 1'b1);
        step("delay_inf",  21'd48, 16'd1,    1'b1, 1'b0, 1'b0, 1'b1);
        viol = 0; n = 0;
        while (start_pulse !== 1'b1 && n < 1500) begin
            @(negedge clk);
            if (start_pulse !== 1'b1 && (bus_we !== 1'b0 || bus_addr !== IA)) viol++;
            n++;
        end
        check("delay_idle_bus", 64'(viol), 64'd0);
        check("delay_go_ts", 64'(timestamp), 64'd1001);
        check("delay_go_bus", 64'({bus_addr, bus_data, bus_we}), 64'({21'd0, 16'd1, 1'b1}));
        step("delay_clear", 21'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("delay_idle",  IA,    16'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Start time already in the past, highest valid pin 7 -> base 256
        send(3'd7, 16'd1, 16'd2, 16'd3, 1'b0, timestamp - 32'd100);
        step("past_duty", 21'd260, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("past_anti", 21'd264, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        step("past_cyc",  21'd268, 16'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        step("past_inf",  21'd272, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("past_wait", IA,      16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("past_go",   21'd0,   16'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("past_clear", 21'd0,  16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("past_idle", IA,      16'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Abort while waiting: CLEAR, IDLE, and the discarded command never launches
        send(3'd0, 16'd9, 16'd9, 16'd9, 1'b0, timestamp + 32'd500);
        repeat (4) @(negedge clk);
        step("abw_wait", IA, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        step("abw_clear", 21'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        abort = 1'b0;
        step("abw_idle", IA, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        pulses = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (start_pulse !== 1'b0 || bus_we !== 1'b0) pulses++;
        end
        check("abw_no_go", 64'(pulses), 64'd0);

        // Abort in IDLE, held for three cycles
        abort = 1'b1;
        step("abi_clear0", 21'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("abi_clear1", 21'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("abi_clear2", 21'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        abort = 1'b0;
        step("abi_idle", IA, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: B is held valid and only accepted after A's CLEAR and one IDLE cycle
        send(3'd1, 16'd21, 16'd22, 16'd23, 1'b0, 32'd0);
        cmd_pin = 3'd3; cmd_duty = 16'd31; cmd_anti_duty = 16'd32; cmd_cycles = 16'd33;
        cmd_run_inf = 1'b1; cmd_start_time = 32'd0; cmd_valid = 1'b1;
        step("b2b_a_duty",  21'd68, 16'd21, 1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_a_anti",  21'd72, 16'd22, 1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_a_cyc",   21'd76, 16'd23, 1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_a_inf",   21'd80, 16'd0,  1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_a_wait",  IA,     16'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        step("b2b_a_go",    21'd0,  16'd1,  1'b1, 1'b1, 1'b0, 1'b1);
        step("b2b_a_clear", 21'd0,  16'd0,  1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_gap",     IA,     16'd0,  1'b0, 1'b0, 1'b1, 1'b0);
        step("b2b_b_duty",  21'd132, 16'd31, 1'b1, 1'b0, 1'b0, 1'b1);
        cmd_valid = 1'b0;
        step("b2b_b_anti",  21'd136, 16'd32, 1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_b_cyc",   21'd140, 16'd33, 1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_b_inf",   21'd144, 16'd1,  1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_b_wait",  IA,      16'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        step("b2b_b_go",    21'd0,   16'd1,  1'b1, 1'b1, 1'b0, 1'b1);
        step("b2b_b_clear", 21'd0,   16'd0,  1'b1, 1'b0, 1'b0, 1'b1);
        step("b2b_b_idle",  IA,      16'd0,  1'b0, 1'b0, 1'b1, 1'b0);

        // Wrap: 8-bit timestamp, accept at 245, start_time 2 must wait past the wrap
        cmd_duty = 16'h0042; cmd_anti_duty = 16'd1; cmd_cycles = 16'd1; cmd_run_inf = 1'b0;
        n = 0;
        while (timestamp2 !== 8'd245 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wrap_sync_ts", 64'(timestamp2), 64'd245);
        check("wrap_ready", 64'(cmd_ready2), 64'd1);
        cmd_pin2 = 3'd5; cmd_start_time2 = 8'd2; cmd_valid2 = 1'b1;
        @(posedge clk);
        #1 cmd_valid2 = 1'b0;
        step2("wrap_duty", 21'd196, 16'h0042, 1'b1, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (start_pulse2 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wrap_go_ts", 64'(timestamp2), 64'd3);
        step2("wrap_clear", 21'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step2("wrap_idle",  IA,    16'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Pin index 6 with six pins: only the global clear write, then IDLE
        cmd_pin2 = 3'd6; cmd_start_time2 = 8'd0; cmd_valid2 = 1'b1;
        @(posedge clk);
        #1 cmd_valid2 = 1'b0;
        step2("badpin_clear", 21'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step2("badpin_idle",  IA,    16'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset during WR_CYC: pin 4 -> base 160
        send(3'd4, 16'd11, 16'd12, 16'd13, 1'b1, 32'd0);
        step("rst_duty", 21'd164, 16'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        step("rst_anti", 21'd168, 16'd12, 1'b1, 1'b0, 1'b0, 1'b1);
        step("rst_cyc",  21'd172, 16'd13, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        step("rst_outs", IA, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_ts", 64'(timestamp), 64'd0);
        reset = 1'b0;
        step("rst_release", IA, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_release_ts", 64'(timestamp), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
